vmvmb_seq_ctrl: RTL
===================

# vmvmb_seq_ctrl

Sequential scheduler for the LSTM gate pre-activation A = Wxᵀ·x + Whᵀ·h_prev + b. It computes the 400-element result one output at a time, using one shared 32×32 MAC. Operands are fetched from external weight, vector and bias memories, each with 1-cycle read latency. It replaces the fully combinational matrix-times-vector datapath wherever area matters more than latency, and streams results out over a valid/ready port.

## Interface
- M_SIZE, 100, length of x and h_prev; row count of Wx and Wh
- N_SIZE, 400, length of b and A; column count of Wx and Wh
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to compute all of A; ignored while busy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final output handshake
- rd_en  out  1  read strobe for the vector and matrix memories
- sel_h  out  1  0 selects x/Wx, 1 selects h_prev/Wh
- vec_addr  out  $clog2(M_SIZE)  vector element index (also the matrix row)
- mat_col  out  $clog2(N_SIZE)  matrix column, equal to the current output index j
- vec_rdata  in  32 signed  vector data, valid the cycle after rd_en
- mat_rdata  in  32 signed  matrix data, valid the cycle after rd_en
- bias_rd_en  out  1  bias read strobe
- bias_addr  out  $clog2(N_SIZE)  bias index j
- bias_rdata  in  32 signed  bias data, valid the cycle after bias_rd_en
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_data  out  32 signed  A[j]
- out_idx  out  $clog2(N_SIZE)  j

## Operation
- States: IDLE, READ, DRAIN, OUT.
- IDLE → READ when start=1. Column j=0, k=0.
- READ issues one read per cycle, k = 0..2M_SIZE−1:
  - k<M_SIZE: sel_h=0, vec_addr=k.
  - k≥M_SIZE: sel_h=1, vec_addr=k−M_SIZE.
  - mat_col=j on every read.
  - bias_rd_en=1 with bias_addr=j only on k=0.
- After k=2M_SIZE−1, READ → DRAIN. DRAIN → OUT unconditionally.
- OUT holds out_valid=1, with out_data and out_idx stable, until out_ready=1.
- On the OUT handshake:
  - j<N_SIZE−1: j++, go to READ.
  - Otherwise go to IDLE and pulse done.
- Accumulator: signed, width 64+$clog2(2M_SIZE+1).
  - First data cycle of a column: acc ← sext(bias_rdata) + vec_rdata·mat_rdata.
  - Later data cycles: acc += product. Products are full 64-bit signed.
- out_data is acc[31:0] (wrap-around) unless saturation is compiled in.
- start while busy has no effect.
- rst_n low at any time, including mid-column or during OUT, immediately forces:
  - state=IDLE, acc=0, j=0.
  - All outputs to 0.
  - Partial results are discarded. The next start begins again at column 0.

## Timing
- Reset values: busy, done, rd_en, bias_rd_en, sel_h, out_valid = 0; vec_addr, mat_col, bias_addr, out_data, out_idx = 0.
- Cycle 0 is the cycle in which start is sampled high. rd_en is high in cycles 1..2M_SIZE of column 0.
- Per column:
  - 2M_SIZE READ cycles, then 1 DRAIN cycle.
  - out_valid rises in the following cycle, 2M_SIZE+1 cycles after the column's first rd_en.
- With out_ready tied high, each column takes 2M_SIZE+2 cycles.
- The next column's first rd_en is the cycle after the handshake.
- No reads are issued during DRAIN or OUT. Backpressure stalls all fetching.
- Final handshake in cycle c: done=1 and busy=0 in cycle c+1.
  - Defaults, no stall: done in cycle 400·202+1 = 80801.

## Configuration
- VMVMB_SAT_EN defined: out_data is acc clamped to [−2^31, 2^31−1]:
  - acc > 2^31−1 → 0x7FFFFFFF.
  - acc < −2^31 → 0x80000000.
- VMVMB_SAT_EN undefined: out_data = acc[31:0], two's-complement wrap.
- Accumulation width and timing are identical in both builds.

## Test plan
- Basic result, M_SIZE=4, N_SIZE=3:
  - Stimulus: x=1, Wx=2, h_prev=3, Wh=1 everywhere; b={5,6,7}; out_ready=1.
  - Response: outputs (idx,data) = (0,25), (1,26), (2,27); done in cycle 3·10+1 = 31.
- Signed arithmetic, M_SIZE=4:
  - Stimulus: x=−1, Wx=3, h_prev=2, Wh=−5, b=10.
  - Response: every out_data = −42.
- Overflow, M_SIZE=4:
  - Stimulus: x=Wx=0x7FFFFFFF, h_prev=0, b=0.
  - Response: out_data=4 without VMVMB_SAT_EN; 0x7FFFFFFF with it.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles at column 1.
  - Response: out_valid, out_data and out_idx stable; rd_en=0 throughout; the next column's rd_en starts the cycle after out_ready=1.
- Start handling and reset:
  - Stimulus: pulse start during READ.
  - Response: ignored, sequence unchanged.
  - Stimulus: drop rst_n during column 2.
  - Response: busy, rd_en and out_valid go to 0 asynchronously; a new start yields out_idx=0 first with correct data.
- Default-size throughput:
  - Stimulus: defaults, random data, out_ready=1.
  - Response: 400 outputs matching the reference model; done in cycle 80801.

Source files
------------

// File: rtl/vmvmb_seq_ctrl.sv
// rtl/vmvmb_seq_ctrl.sv - sequential LSTM gate pre-activation scheduler, one shared MAC (option: VMVMB_SAT_EN saturates out_data)
module vmvmb_seq_ctrl #(
    parameter int M_SIZE = 100,
    parameter int N_SIZE = 400
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic                          sel_h,
    output logic [$clog2(M_SIZE)-1:0]     vec_addr,
    output logic [$clog2(N_SIZE)-1:0]     mat_col,
    input  logic signed [31:0]            vec_rdata,
    input  logic signed [31:0]            mat_rdata,
    output logic                          bias_rd_en,
    output logic [$clog2(N_SIZE)-1:0]     bias_addr,
    input  logic signed [31:0]            bias_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [31:0]            out_data,
    output logic [$clog2(N_SIZE)-1:0]     out_idx
);

    localparam int VW = $clog2(M_SIZE);
    localparam int NW = $clog2(N_SIZE);
    localparam int KW = $clog2(2 * M_SIZE);
    localparam int AW = 64 + $clog2(2 * M_SIZE + 1);

    localparam logic [KW-1:0] K_LAST = KW'(2 * M_SIZE - 1);
    localparam logic [KW-1:0] K_HALF = KW'(M_SIZE);
    localparam logic [VW-1:0] V_OFS  = VW'(M_SIZE);
    localparam logic [NW-1:0] J_LAST = NW'(N_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [KW-1:0]          r_k;
    logic [NW-1:0]          r_j;
    logic signed [AW-1:0]   r_acc;
    logic                   r_data_vld;
    logic                   r_data_first;
    logic                   r_done;

    logic                   w_rd;
    logic                   w_hi_half;
    logic                   w_hs;
    logic signed [63:0]     w_prod;
    logic signed [AW-1:0]   w_prod_ext;
    logic signed [AW-1:0]   w_bias_ext;
    logic signed [31:0]     w_out;

    // Next-state logic; reads are issued only while in READ
    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_rd = 1'b1;
                if (r_k == K_LAST) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = (r_j == J_LAST) ? S_IDLE : S_READ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_hs      = (r_state == S_OUT) && out_ready;
    assign w_hi_half = (r_k >= K_HALF);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read index k walks x then h_prev once per column and wraps to 0 for the next column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
        end else if (w_rd) begin
            r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
        end else if (r_state != S_READ) begin
            r_k <= '0;
        end
    end

    // Column index j advances on each output handshake and returns to 0 after the last column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j <= '0;
        end else if (w_hs) begin
            r_j <= (r_j == J_LAST) ? '0 : r_j + 1'b1;
        end
    end

    // Memory data arrives one cycle after the strobe; track which cycles carry operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_vld   <= 1'b0;
            r_data_first <= 1'b0;
        end else begin
            r_data_vld   <= w_rd;
            r_data_first <= w_rd && (r_k == '0);
        end
    end

    assign w_prod     = $signed({{32{vec_rdata[31]}}, vec_rdata}) *
                        $signed({{32{mat_rdata[31]}}, mat_rdata});
    assign w_prod_ext = {{(AW-64){w_prod[63]}}, w_prod};
    assign w_bias_ext = {{(AW-32){bias_rdata[31]}}, bias_rdata};

    // Accumulator: the first operand pair of a column also folds in the bias
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_data_vld) begin
            if (r_data_first) begin
                r_acc <= w_bias_ext + w_prod_ext;
            end else begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    // Completion pulse follows the handshake of the last column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_hs && (r_j == J_LAST);
        end
    end

`ifdef VMVMB_SAT_EN
    logic w_ovf;
    // Out of 32-bit range when the bits above bit 30 are not all copies of the sign
    assign w_ovf = (|r_acc[AW-1:31]) && !(&r_acc[AW-1:31]);
    assign w_out = w_ovf ? (r_acc[AW-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : r_acc[31:0];
`else
    assign w_out = r_acc[31:0];
`endif

    // vec_addr uses modular arithmetic in VW bits: k-M_SIZE always fits below M_SIZE
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign rd_en      = w_rd;
    assign sel_h      = w_rd && w_hi_half;
    assign vec_addr   = !w_rd ? '0 : (w_hi_half ? r_k[VW-1:0] - V_OFS : r_k[VW-1:0]);
    assign mat_col    = r_j;
    assign bias_rd_en = w_rd && (r_k == '0);
    assign bias_addr  = r_j;
    assign out_valid  = (r_state == S_OUT);
    assign out_data   = w_out;
    assign out_idx    = r_j;

endmodule
